// File: rtl/io_pkg.sv
// Shared constants and types for the processor I/O port unit and its TX FIFO.
package io_pkg;

  localparam int DATA_W_DEFAULT   = 16;
  localparam int TX_DEPTH_DEFAULT = 4;

  // Bit positions inside the sticky status vector.
  localparam int STAT_TX_OVF = 1;
  localparam int STAT_RX_UDF = 0;

  typedef logic [1:0] status_t;

endpackage

// File: rtl/io_fifo.sv
// Power-of-two FIFO with extra-MSB pointers; the head word is read from flops only.
module io_fifo
  import io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = TX_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic              popOk, pushOk;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign popOk  = pop & ~empty;
  // A push into a full FIFO is only legal when the head slot is freed this cycle.
  assign pushOk = push & (~full | popOk);
  assign rdata  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (pushOk) wptr_d = wptr_q + PTR_ONE;
    if (popOk)  rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (pushOk) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/io_port_unit.sv
// Processor I/O port: buffered OUT path to a valid/ready sink, one-word IN holding
// register from a valid/ready source, and sticky overflow/underflow flags.
module io_port_unit
  import io_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int TX_DEPTH = TX_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] out_data,
  input  logic              in_rd,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_full,
  output logic [1:0]        status,
  input  logic              status_clr
);

  logic              fifoFull, fifoEmpty;
  logic              popFire, pushFire, txOverflow;
  logic              rxFire, rxUnderflow;
  logic [DATA_W-1:0] inData_q, inData_d;
  logic              inValid_q, inValid_d;
  status_t           status_q, status_d;

  assign popFire    = ~fifoEmpty & tx_ready;
  assign pushFire   = out_wr & (~fifoFull | popFire);
  assign txOverflow = out_wr & fifoFull & ~popFire;

  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TX_DEPTH)
  ) u_txFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pushFire),
    .pop   (popFire),
    .wdata (out_data),
    .rdata (tx_data),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign tx_valid = ~fifoEmpty;
  assign tx_full  = fifoFull;

  // The holding register may refill in the same cycle the processor consumes it.
  assign rx_ready    = ~inValid_q | in_rd;
  assign rxFire      = rx_valid & rx_ready;
  assign rxUnderflow = in_rd & ~inValid_q;

  always_comb begin
    inData_d  = inData_q;
    inValid_d = inValid_q;
    status_d  = status_q;
    if (rxFire) begin
      inData_d  = rx_data;
      inValid_d = 1'b1;
    end else if (in_rd) begin
      inValid_d = 1'b0;
    end
    // Clear first so a coincident set event takes priority.
    if (status_clr) status_d = '0;
    if (txOverflow)  status_d[STAT_TX_OVF] = 1'b1;
    if (rxUnderflow) status_d[STAT_RX_UDF] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inData_q  <= '0;
      inValid_q <= 1'b0;
      status_q  <= '0;
    end else begin
      inData_q  <= inData_d;
      inValid_q <= inValid_d;
      status_q  <= status_d;
    end
  end

  assign in_data  = inData_q;
  assign in_valid = inValid_q;
  assign status   = status_q;

endmodule
